// File: rtl/axi_lite_imem_loader.sv
// AXI4-Lite write-only slave that turns single-beat writes into instruction-memory
// strobes and holds the CPU in reset while an image is being loaded.
module axi_lite_imem_loader #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int HOLD_CYCLES    = 134217727,
  parameter int HOLD_CNT_WIDTH = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [31:0]               i_s_axi_awaddr,
  input  logic [2:0]                i_s_axi_awprot,
  input  logic                      i_s_axi_awvalid,
  output logic                      o_s_axi_awready,
  input  logic [31:0]               i_s_axi_wdata,
  input  logic [3:0]                i_s_axi_wstrb,
  input  logic                      i_s_axi_wvalid,
  output logic                      o_s_axi_wready,
  output logic [1:0]                o_s_axi_bresp,
  output logic                      o_s_axi_bvalid,
  input  logic                      i_s_axi_bready,
  input  logic [31:0]               i_s_axi_araddr,
  input  logic [2:0]                i_s_axi_arprot,
  input  logic                      i_s_axi_arvalid,
  output logic                      o_s_axi_arready,
  output logic [31:0]               o_s_axi_rdata,
  output logic [1:0]                o_s_axi_rresp,
  output logic                      o_s_axi_rvalid,
  input  logic                      i_s_axi_rready,
  output logic                      o_mem_en,
  output logic [3:0]                o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]               o_mem_wrdata,
  output logic                      o_cpu_hold
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  wr_state_t                 wr_state;
  rd_state_t                 rd_state;
  logic                      aw_captured;
  logic                      w_captured;
  logic [31:0]               aw_addr;
  logic [31:0]               w_data;
  logic [3:0]                w_strb;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt;

  logic        aw_hs;
  logic        w_hs;
  logic        aw_done;
  logic        w_done;
  logic        in_range;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;

  // Merge a beat arriving this cycle with one captured earlier so both can complete on one edge.
  always_comb begin
    aw_hs    = i_s_axi_awvalid && o_s_axi_awready;
    w_hs     = i_s_axi_wvalid && o_s_axi_wready;
    aw_done  = aw_captured || aw_hs;
    w_done   = w_captured || w_hs;
    cur_addr = aw_hs ? i_s_axi_awaddr : aw_addr;
    cur_data = w_hs ? i_s_axi_wdata : w_data;
    cur_strb = w_hs ? i_s_axi_wstrb : w_strb;
    in_range = (cur_addr >> MEM_ADDR_WIDTH) == 32'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state        <= W_IDLE;
      aw_captured     <= 1'b0;
      w_captured      <= 1'b0;
      aw_addr         <= '0;
      w_data          <= '0;
      w_strb          <= '0;
      o_s_axi_awready <= 1'b0;
      o_s_axi_wready  <= 1'b0;
      o_s_axi_bvalid  <= 1'b0;
      o_s_axi_bresp   <= RESP_OKAY;
      o_mem_en        <= 1'b0;
      o_mem_we        <= '0;
      o_mem_addr      <= '0;
      o_mem_wrdata    <= '0;
    end else begin
      o_mem_en     <= 1'b0;
      o_mem_we     <= '0;
      o_mem_addr   <= '0;
      o_mem_wrdata <= '0;
      unique case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_captured <= 1'b1;
            aw_addr     <= i_s_axi_awaddr;
          end
          if (w_hs) begin
            w_captured <= 1'b1;
            w_data     <= i_s_axi_wdata;
            w_strb     <= i_s_axi_wstrb;
          end
          if (aw_done && w_done) begin
            wr_state        <= W_MEM;
            o_s_axi_awready <= 1'b0;
            o_s_axi_wready  <= 1'b0;
            if (in_range) begin
              o_mem_en      <= 1'b1;
              o_mem_we      <= cur_strb;
              o_mem_addr    <= {cur_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
              o_mem_wrdata  <= cur_data;
              o_s_axi_bresp <= RESP_OKAY;
            end else begin
              o_s_axi_bresp <= RESP_SLVERR;
            end
          end else begin
            o_s_axi_awready <= !aw_done;
            o_s_axi_wready  <= !w_done;
          end
        end
        W_MEM: begin
          o_s_axi_bvalid <= 1'b1;
          wr_state       <= W_RESP;
        end
        W_RESP: begin
          if (i_s_axi_bready) begin
            o_s_axi_bvalid  <= 1'b0;
            o_s_axi_bresp   <= RESP_OKAY;
            aw_captured     <= 1'b0;
            w_captured      <= 1'b0;
            o_s_axi_awready <= 1'b1;
            o_s_axi_wready  <= 1'b1;
            wr_state        <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Reads are never serviced: every AR gets a single SLVERR beat with zero data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state        <= R_IDLE;
      o_s_axi_arready <= 1'b0;
      o_s_axi_rvalid  <= 1'b0;
      o_s_axi_rresp   <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (i_s_axi_arvalid && o_s_axi_arready) begin
            o_s_axi_arready <= 1'b0;
            o_s_axi_rvalid  <= 1'b1;
            o_s_axi_rresp   <= RESP_SLVERR;
            rd_state        <= R_RESP;
          end else begin
            o_s_axi_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (i_s_axi_rready) begin
            o_s_axi_rvalid  <= 1'b0;
            o_s_axi_rresp   <= RESP_OKAY;
            o_s_axi_arready <= 1'b1;
            rd_state        <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Hold tracks the next counter value so it rises the cycle right after the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_cnt   <= '0;
      o_cpu_hold <= 1'b0;
    end else if (wr_state == W_MEM && o_mem_en && (|o_mem_we)) begin
      hold_cnt   <= HOLD_CNT_WIDTH'(HOLD_CYCLES);
      o_cpu_hold <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt   <= hold_cnt - HOLD_CNT_WIDTH'(1);
      o_cpu_hold <= (hold_cnt != HOLD_CNT_WIDTH'(1));
    end
  end

  assign o_s_axi_rdata = 32'd0;

  logic unused_inputs;
  assign unused_inputs = ^{i_s_axi_awprot, i_s_axi_araddr, i_s_axi_arprot, aw_addr[1:0]};

endmodule

// File: tb/tb_axi_lite_imem_loader.sv
// Self-checking bench for axi_lite_imem_loader: vector table, scoreboard queues and hand-written corner cases.
module tb_axi_lite_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_s_axi_awaddr;
  logic [2:0]  i_s_axi_awprot;
  logic        i_s_axi_awvalid;
  logic        o_s_axi_awready;
  logic [31:0] i_s_axi_wdata;
  logic [3:0]  i_s_axi_wstrb;
  logic        i_s_axi_wvalid;
  logic        o_s_axi_wready;
  logic [1:0]  o_s_axi_bresp;
  logic        o_s_axi_bvalid;
  logic        i_s_axi_bready;
  logic [31:0] i_s_axi_araddr;
  logic [2:0]  i_s_axi_arprot;
  logic        i_s_axi_arvalid;
  logic        o_s_axi_arready;
  logic [31:0] o_s_axi_rdata;
  logic [1:0]  o_s_axi_rresp;
  logic        o_s_axi_rvalid;
  logic        i_s_axi_rready;
  logic        o_mem_en;
  logic [3:0]  o_mem_we;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wrdata;
  logic        o_cpu_hold;

  axi_lite_imem_loader #(.MEM_ADDR_WIDTH(16), .HOLD_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_s_axi_awaddr(i_s_axi_awaddr), .i_s_axi_awprot(i_s_axi_awprot),
    .i_s_axi_awvalid(i_s_axi_awvalid), .o_s_axi_awready(o_s_axi_awready),
    .i_s_axi_wdata(i_s_axi_wdata), .i_s_axi_wstrb(i_s_axi_wstrb),
    .i_s_axi_wvalid(i_s_axi_wvalid), .o_s_axi_wready(o_s_axi_wready),
    .o_s_axi_bresp(o_s_axi_bresp), .o_s_axi_bvalid(o_s_axi_bvalid),
    .i_s_axi_bready(i_s_axi_bready),
    .i_s_axi_araddr(i_s_axi_araddr), .i_s_axi_arprot(i_s_axi_arprot),
    .i_s_axi_arvalid(i_s_axi_arvalid), .o_s_axi_arready(o_s_axi_arready),
    .o_s_axi_rdata(o_s_axi_rdata), .o_s_axi_rresp(o_s_axi_rresp),
    .o_s_axi_rvalid(o_s_axi_rvalid), .i_s_axi_rready(i_s_axi_rready),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wrdata(o_mem_wrdata), .o_cpu_hold(o_cpu_hold)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    bit          exp_strobe;
    logic [3:0]  exp_we;
    logic [15:0] exp_addr;
    logic [1:0]  exp_bresp;
    bit          exp_hold;
  } vec_t;

  typedef struct {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  mem_exp_t   mem_q[$];
  logic [1:0] resp_q[$];
  mem_exp_t   mon_e;
  logic [1:0] mon_r;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int last_trig = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  int rise_count = 0;
  logic prev_hold = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: pops expected strobes and responses as the DUT produces them.
  always @(negedge i_clk) begin
    ncyc++;
    if (!i_rst) begin
      if (o_mem_en) begin
        if (mem_q.size() == 0) begin
          check_output("unexpected_strobe", 64'(o_mem_addr), 64'hFFFF_FFFF);
        end else begin
          mon_e = mem_q.pop_front();
          check_output("mem_we", 64'(o_mem_we), 64'(mon_e.we));
          check_output("mem_addr", 64'(o_mem_addr), 64'(mon_e.addr));
          check_output("mem_wrdata", 64'(o_mem_wrdata), 64'(mon_e.data));
        end
        if (|o_mem_we) last_trig = ncyc;
      end else begin
        check_output("mem_idle_zero", {o_mem_we, o_mem_addr, o_mem_wrdata}, 64'd0);
      end
      if (o_s_axi_bvalid && i_s_axi_bready) begin
        if (resp_q.size() == 0) begin
          check_output("unexpected_bresp", 64'(o_s_axi_bresp), 64'hF);
        end else begin
          mon_r = resp_q.pop_front();
          check_output("bresp", 64'(o_s_axi_bresp), 64'(mon_r));
        end
      end
    end
    if (o_cpu_hold && !prev_hold) begin
      rise_cyc = ncyc;
      rise_count++;
    end
    if (!o_cpu_hold && prev_hold) fall_cyc = ncyc;
    prev_hold = o_cpu_hold;
  end

  // Called at posedge+1; drives AW and W with independent delays and optionally waits for B.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input int aw_dly, input int w_dly, input bit wait_b);
    int  cyc = 0;
    bit  aw_ok = 0;
    bit  w_ok = 0;
    bit  aw_fire;
    bit  w_fire;
    i_s_axi_awaddr = addr;
    i_s_axi_wdata  = data;
    i_s_axi_wstrb  = strb;
    while (!(aw_ok && w_ok)) begin
      if (cyc >= 50) begin
        check_output("handshake_timeout", 64'd0, 64'd1);
        break;
      end
      i_s_axi_awvalid = !aw_ok && (cyc >= aw_dly);
      i_s_axi_wvalid  = !w_ok && (cyc >= w_dly);
      @(negedge i_clk);
      aw_fire = i_s_axi_awvalid && o_s_axi_awready;
      w_fire  = i_s_axi_wvalid && o_s_axi_wready;
      if (w_ok && !aw_ok) check_output("wready_low_after_w", 64'(o_s_axi_wready), 64'd0);
      if (aw_ok && !w_ok) check_output("awready_low_after_aw", 64'(o_s_axi_awready), 64'd0);
      @(posedge i_clk);
      #1;
      aw_ok = aw_ok || aw_fire;
      w_ok  = w_ok || w_fire;
      cyc++;
    end
    i_s_axi_awvalid = 1'b0;
    i_s_axi_wvalid  = 1'b0;
    if (wait_b) begin
      cyc = 0;
      forever begin
        @(negedge i_clk);
        check_output("readies_low_until_b", {o_s_axi_awready, o_s_axi_wready}, 64'd0);
        if (o_s_axi_bvalid && i_s_axi_bready) break;
        if (++cyc >= 20) begin
          check_output("bvalid_timeout", 64'd0, 64'd1);
          break;
        end
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_hold_clear();
    int cyc = 0;
    forever begin
      @(negedge i_clk);
      if (!o_cpu_hold) break;
      if (++cyc >= 40) begin
        check_output("hold_clear_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1, 4'hF, 16'h0010, 2'b00, 1'b1};
    vecs[1] = '{32'h0000_0123, 32'h1122_3344, 4'h3, 3, 0, 1'b1, 4'h3, 16'h0120, 2'b00, 1'b1};
    vecs[2] = '{32'h0001_0000, 32'h5555_AAAA, 4'hF, 0, 0, 1'b0, 4'h0, 16'h0000, 2'b10, 1'b0};
    vecs[3] = '{32'h0000_FFFC, 32'hCAFE_F00D, 4'hC, 0, 2, 1'b1, 4'hC, 16'hFFFC, 2'b00, 1'b1};
    vecs[4] = '{32'h0000_0040, 32'h0BAD_CAFE, 4'h0, 1, 0, 1'b1, 4'h0, 16'h0040, 2'b00, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 0, 0, 1'b0, 4'h0, 16'h0000, 2'b10, 1'b0};
    vecs[6] = '{32'h0000_FFFF, 32'h8765_4321, 4'h1, 2, 2, 1'b1, 4'h1, 16'hFFFC, 2'b00, 1'b1};

    i_rst = 1'b1;
    i_s_axi_awaddr = '0; i_s_axi_awprot = '0; i_s_axi_awvalid = 1'b0;
    i_s_axi_wdata = '0; i_s_axi_wstrb = '0; i_s_axi_wvalid = 1'b0;
    i_s_axi_bready = 1'b1;
    i_s_axi_araddr = '0; i_s_axi_arprot = '0; i_s_axi_arvalid = 1'b0;
    i_s_axi_rready = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_output("reset_readies", {o_s_axi_awready, o_s_axi_wready, o_s_axi_arready}, 64'd0);
    check_output("reset_valids", {o_s_axi_bvalid, o_s_axi_rvalid, o_s_axi_bresp, o_s_axi_rresp}, 64'd0);
    check_output("reset_mem_hold", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wrdata, o_cpu_hold}, 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("post_reset_readies", {o_s_axi_awready, o_s_axi_wready, o_s_axi_arready}, 64'b111);
    @(posedge i_clk); #1;

    // Same-cycle AW/W: exact strobe/bvalid latency and an 8-cycle hold
    rise_count = 0;
    mem_q.push_back('{4'hF, 16'h0010, 32'hDEAD_BEEF});
    resp_q.push_back(2'b00);
    i_s_axi_awaddr = 32'h0000_0010; i_s_axi_wdata = 32'hDEAD_BEEF; i_s_axi_wstrb = 4'hF;
    i_s_axi_awvalid = 1'b1; i_s_axi_wvalid = 1'b1;
    @(negedge i_clk);
    check_output("lat_readies", {o_s_axi_awready, o_s_axi_wready}, 64'b11);
    @(posedge i_clk); #1;
    i_s_axi_awvalid = 1'b0; i_s_axi_wvalid = 1'b0;
    @(negedge i_clk);
    check_output("lat_strobe_cycle", {o_mem_en, o_s_axi_bvalid, o_cpu_hold}, 64'b100);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("lat_bvalid_cycle", {o_mem_en, o_s_axi_bvalid, o_cpu_hold}, 64'b011);
    @(posedge i_clk); #1;
    wait_hold_clear();
    check_output("hold_rise_after_strobe", 64'(rise_cyc - last_trig), 64'd1);
    check_output("hold_length", 64'(fall_cyc - rise_cyc), 64'd8);
    check_output("hold_single_rise", 64'(rise_count), 64'd1);

    // Table-driven writes
    foreach (vecs[i]) begin
      wait_hold_clear();
      if (vecs[i].exp_strobe) mem_q.push_back('{vecs[i].exp_we, vecs[i].exp_addr, vecs[i].wdata});
      resp_q.push_back(vecs[i].exp_bresp);
      apply_stimulus(vecs[i].awaddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].aw_dly, vecs[i].w_dly, 1'b1);
      @(negedge i_clk);
      check_output($sformatf("vec%0d_hold", i), 64'(o_cpu_hold), 64'(vecs[i].exp_hold));
      @(posedge i_clk); #1;
    end

    // Retrigger: second write shortly after the first keeps hold continuous
    wait_hold_clear();
    rise_count = 0;
    mem_q.push_back('{4'hF, 16'h0200, 32'hA5A5_0001});
    resp_q.push_back(2'b00);
    apply_stimulus(32'h0000_0200, 32'hA5A5_0001, 4'hF, 0, 0, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    mem_q.push_back('{4'hF, 16'h0204, 32'hA5A5_0002});
    resp_q.push_back(2'b00);
    apply_stimulus(32'h0000_0204, 32'hA5A5_0002, 4'hF, 0, 0, 1'b1);
    wait_hold_clear();
    check_output("retrig_single_rise", 64'(rise_count), 64'd1);
    check_output("retrig_fall_after_second", 64'(fall_cyc - last_trig), 64'd9);

    // Read held off by rready while a write runs concurrently
    mem_q.push_back('{4'h6, 16'h0300, 32'h0F0F_F0F0});
    resp_q.push_back(2'b00);
    fork
      begin
        i_s_axi_araddr = 32'h0; i_s_axi_arvalid = 1'b1; i_s_axi_rready = 1'b0;
        @(negedge i_clk);
        check_output("arready_idle", 64'(o_s_axi_arready), 64'd1);
        @(posedge i_clk); #1;
        i_s_axi_arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge i_clk);
          check_output($sformatf("read_hold%0d", k), {o_s_axi_rvalid, o_s_axi_rresp, o_s_axi_rdata}, {1'b1, 2'b10, 32'd0});
        end
        @(posedge i_clk); #1;
        i_s_axi_rready = 1'b1;
        @(negedge i_clk);
        check_output("read_rvalid_at_hs", 64'(o_s_axi_rvalid), 64'd1);
        @(posedge i_clk); #1;
        i_s_axi_rready = 1'b0;
        @(negedge i_clk);
        check_output("read_done", {o_s_axi_rvalid, o_s_axi_arready}, 64'b01);
      end
      apply_stimulus(32'h0000_0302, 32'h0F0F_F0F0, 4'h6, 1, 0, 1'b1);
    join
    @(posedge i_clk); #1;

    // Reset while in W_RESP with hold active
    wait_hold_clear();
    i_s_axi_bready = 1'b0;
    mem_q.push_back('{4'hF, 16'h0400, 32'h7777_8888});
    resp_q.push_back(2'b00);
    apply_stimulus(32'h0000_0400, 32'h7777_8888, 4'hF, 0, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_s_axi_bvalid) break;
    end
    check_output("pre_reset_bvalid_hold", {o_s_axi_bvalid, o_cpu_hold}, 64'b11);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("mid_reset_cleared", {o_s_axi_bvalid, o_cpu_hold, o_s_axi_awready, o_mem_en}, 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_s_axi_bready = 1'b1;
    resp_q.delete();
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check_output("after_reset_readies", {o_s_axi_awready, o_s_axi_wready, o_s_axi_arready}, 64'b111);
    check_output("after_reset_quiet", {o_s_axi_bvalid, o_cpu_hold}, 64'd0);
    @(posedge i_clk); #1;

    check_output("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check_output("resp_q_drained", 64'(resp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
